// File: rtl/zebra_stripe_analyzer.sv
// Zebra-crossing analyser for a raster pixel stream.
// Pixels are binarised against a per-frame threshold. White runs of at least
// MIN_RUN pixels on N_SCAN_ROWS scan rows are counted, rows are voted at the
// end of each frame, and the frame decision is passed through confirm/release
// hysteresis before driving crossing_detected.
//
// Stream handshake: a pixel transfers on every rising clk edge where
// x_valid && x_ready. x_data must be stable while x_valid is high; x_ready
// is high only while scanning and drops for the two end-of-frame cycles.
// The source may insert idle cycles at any point.
module zebra_stripe_analyzer #(
   parameter int IMG_WIDTH      = 640,
   parameter int IMG_HEIGHT     = 480,
   parameter int W              = 8,
   parameter int N_SCAN_ROWS    = 4,
   parameter int ROW_START      = 240,
   parameter int ROW_STEP       = 40,
   parameter int MIN_RUN        = 8,
   parameter int MIN_STRIPES    = 3,
   parameter int MAX_STRIPES    = 12,
   parameter int ROW_VOTES      = 3,
   parameter int CONFIRM_FRAMES = 2,
   parameter int RELEASE_FRAMES = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               x_valid,
   output logic                               x_ready,
   input  logic [W-1:0]                       x_data,
   input  logic [W-1:0]                       threshold,
   output logic                               crossing_detected,
   output logic                               detection_valid,
   output logic [7:0]                         stripe_count,
   output logic [$clog2(N_SCAN_ROWS+1)-1:0]   rows_voted,
   output logic [1:0]                         fsm_state
);

   localparam int XW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int RW  = $clog2(MIN_RUN + 1);
   localparam int HW  = $clog2(CONFIRM_FRAMES + 1);
   localparam int MW  = $clog2(RELEASE_FRAMES + 1);
   localparam int RVW = $clog2(N_SCAN_ROWS + 1);

   localparam logic [XW-1:0]  X_LAST    = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0]  RUN_MAX   = RW'(MIN_RUN);
   localparam logic [HW-1:0]  CONF_LAST = HW'(CONFIRM_FRAMES - 1);
   localparam logic [MW-1:0]  REL_LAST  = MW'(RELEASE_FRAMES - 1);
   localparam logic [RVW-1:0] VOTES_REQ = RVW'(ROW_VOTES);

   typedef enum logic [1:0] {
      S_SCAN   = 2'd0,
      S_EVAL   = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   state_t         state, state_next;
   logic [XW-1:0]  x_cnt;
   logic [YW-1:0]  y_cnt;
   logic [W-1:0]   thr_lat;
   logic [RW-1:0]  run_cnt;
   logic [7:0]     stripe_cnt [N_SCAN_ROWS];
   logic [HW-1:0]  hit_cnt;
   logic [MW-1:0]  miss_cnt;

   logic                    accept, first_px, frame_last, white;
   logic [W-1:0]            thr_eff;
   logic [RW-1:0]           run_base, run_len, ended_len;
   logic                    run_end, stripe_inc;
   logic [N_SCAN_ROWS-1:0]  row_act;
   logic [RVW-1:0]          votes;
   logic [7:0]              max_cnt;
   logic                    frame_hit;

   assign x_ready    = (state == S_SCAN) && !rst;
   assign accept     = x_valid && x_ready;
   assign first_px   = (x_cnt == '0) && (y_cnt == '0);
   assign frame_last = accept && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
   assign fsm_state  = state;

   // Pixel classification and white-run termination for the current pixel
   always_comb begin
      thr_eff    = first_px ? threshold : thr_lat;
      white      = (x_data >= thr_eff);
      run_base   = (x_cnt == '0) ? '0 : run_cnt;
      run_len    = (run_base == RUN_MAX) ? RUN_MAX : run_base + RW'(1);
      ended_len  = white ? run_len : run_base;
      run_end    = !white || (x_cnt == X_LAST);
      stripe_inc = run_end && (ended_len == RUN_MAX);
      for (int i = 0; i < N_SCAN_ROWS; i++) begin
         row_act[i] = (y_cnt == YW'(ROW_START + i * ROW_STEP));
      end
   end

   // End-of-frame row vote and maximum stripe count
   always_comb begin
      votes   = '0;
      max_cnt = '0;
      for (int i = 0; i < N_SCAN_ROWS; i++) begin
         if ((stripe_cnt[i] >= 8'(MIN_STRIPES)) && (stripe_cnt[i] <= 8'(MAX_STRIPES)))
            votes = votes + RVW'(1);
         if (stripe_cnt[i] > max_cnt)
            max_cnt = stripe_cnt[i];
      end
      frame_hit = (votes >= VOTES_REQ);
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_SCAN;
      else     state <= state_next;
   end

   // FSM next state: scan until the last pixel, then one evaluate and one report cycle
   always_comb begin
      state_next = state;
      case (state)
         S_SCAN:   if (frame_last) state_next = S_EVAL;
         S_EVAL:   state_next = S_REPORT;
         S_REPORT: state_next = S_SCAN;
         default:  state_next = S_SCAN;
      endcase
   end

   // Raster position, frame threshold latch and running white-run length
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         thr_lat <= '0;
         run_cnt <= '0;
      end else if (accept) begin
         if (first_px) thr_lat <= threshold;
         run_cnt <= white ? run_len : '0;
         if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + YW'(1);
         end else begin
            x_cnt <= x_cnt + XW'(1);
         end
      end
   end

   // Per-row stripe counters; cleared in REPORT so each frame starts from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SCAN_ROWS; i++) stripe_cnt[i] <= '0;
      end else if (state == S_REPORT) begin
         for (int i = 0; i < N_SCAN_ROWS; i++) stripe_cnt[i] <= '0;
      end else if (accept && stripe_inc) begin
         for (int i = 0; i < N_SCAN_ROWS; i++)
            if (row_act[i] && (stripe_cnt[i] != 8'hFF))
               stripe_cnt[i] <= stripe_cnt[i] + 8'd1;
      end
   end

   // Registered frame results and confirm/release hysteresis, updated in EVAL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crossing_detected <= 1'b0;
         detection_valid   <= 1'b0;
         stripe_count      <= '0;
         rows_voted        <= '0;
         hit_cnt           <= '0;
         miss_cnt          <= '0;
      end else begin
         detection_valid <= (state == S_EVAL);
         if (state == S_EVAL) begin
            rows_voted   <= votes;
            stripe_count <= max_cnt;
            if (!crossing_detected) begin
               if (frame_hit) begin
                  miss_cnt <= '0;
                  if (hit_cnt == CONF_LAST) begin
                     crossing_detected <= 1'b1;
                     hit_cnt           <= '0;
                  end else begin
                     hit_cnt <= hit_cnt + HW'(1);
                  end
               end else begin
                  hit_cnt <= '0;
               end
            end else begin
               if (!frame_hit) begin
                  hit_cnt <= '0;
                  if (miss_cnt == REL_LAST) begin
                     crossing_detected <= 1'b0;
                     miss_cnt          <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + MW'(1);
                  end
               end else begin
                  miss_cnt <= '0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_zebra_stripe_analyzer.sv
// Self-checking bench for zebra_stripe_analyzer on a 64x16 image.
// Frames are built in an array, streamed with optional idle gaps, and the
// reported results are compared with a reference computed directly from the
// frame contents (full run lengths per scan row, vote, hysteresis).
module tb_zebra_stripe_analyzer;

   localparam int IMG_W   = 64;
   localparam int IMG_H   = 16;
   localparam int NROWS   = 4;
   localparam int RSTART  = 2;
   localparam int RSTEP   = 4;
   localparam int MINRUN  = 4;
   localparam int MINS    = 3;
   localparam int MAXS    = 6;
   localparam int VOTES   = 3;
   localparam int CONF    = 2;
   localparam int REL     = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       x_valid;
   logic       x_ready;
   logic [7:0] x_data;
   logic [7:0] threshold;
   logic       crossing_detected;
   logic       detection_valid;
   logic [7:0] stripe_count;
   logic [2:0] rows_voted;
   logic [1:0] fsm_state;

   zebra_stripe_analyzer #(
      .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H), .W(8), .N_SCAN_ROWS(NROWS),
      .ROW_START(RSTART), .ROW_STEP(RSTEP), .MIN_RUN(MINRUN),
      .MIN_STRIPES(MINS), .MAX_STRIPES(MAXS), .ROW_VOTES(VOTES),
      .CONFIRM_FRAMES(CONF), .RELEASE_FRAMES(REL)
   ) dut (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x_ready(x_ready),
      .x_data(x_data), .threshold(threshold),
      .crossing_detected(crossing_detected), .detection_valid(detection_valid),
      .stripe_count(stripe_count), .rows_voted(rows_voted), .fsm_state(fsm_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int errors = 0;
   int checks = 0;

   logic [7:0] frm [IMG_H][IMG_W];

   // reference hysteresis state
   int m_det = 0;
   int m_hit = 0;
   int m_miss = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_scan_row(input int y);
      for (int i = 0; i < NROWS; i++)
         if (y == RSTART + i * RSTEP) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- frame builders ----------------
   // Non-scan rows are full-range noise; scan rows start as random black.
   task automatic fill_base();
      for (int y = 0; y < IMG_H; y++)
         for (int x = 0; x < IMG_W; x++)
            frm[y][x] = is_scan_row(y) ? 8'($urandom_range(0, 127))
                                       : 8'($urandom_range(0, 255));
   endtask

   task automatic put_bar(input int y, input int x0, input int w, input int val);
      for (int x = x0; x < x0 + w && x < IMG_W; x++)
         frm[y][x] = (val < 0) ? 8'($urandom_range(128, 255)) : 8'(val);
   endtask

   // nbars bars of width w with equal black gaps, on scan rows in rowmask
   task automatic fill_bars(input int w, input int nbars, input int rowmask);
      fill_base();
      for (int i = 0; i < NROWS; i++)
         if (rowmask[i])
            for (int k = 0; k < nbars; k++)
               put_bar(RSTART + i * RSTEP, k * 2 * w, w, 200);
   endtask

   // 3 countable bars, two of them exactly at threshold and one ending at x=63,
   // plus a 3-wide bar that must not count
   task automatic fill_boundary();
      fill_base();
      for (int i = 0; i < NROWS; i++) begin
         put_bar(RSTART + i * RSTEP, 0, 4, 200);
         put_bar(RSTART + i * RSTEP, 20, 4, 128);
         put_bar(RSTART + i * RSTEP, 40, 3, 255);
         put_bar(RSTART + i * RSTEP, 60, 4, 128);
      end
   endtask

   task automatic fill_random();
      int x, w;
      fill_base();
      for (int i = 0; i < NROWS; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            x = $urandom_range(0, 6);
            while (x < IMG_W) begin
               w = $urandom_range(1, 8);
               put_bar(RSTART + i * RSTEP, x, w, -1);
               x = x + w + $urandom_range(1, 6);
            end
         end
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void model_frame(input int thr, output int sc, output int rv);
      int len, cnt, y;
      sc = 0;
      rv = 0;
      for (int i = 0; i < NROWS; i++) begin
         y = RSTART + i * RSTEP;
         len = 0;
         cnt = 0;
         for (int x = 0; x < IMG_W; x++) begin
            if (int'(frm[y][x]) >= thr) len++;
            else begin
               if (len >= MINRUN) cnt++;
               len = 0;
            end
         end
         if (len >= MINRUN) cnt++;
         if (cnt > 255) cnt = 255;
         if (cnt > sc) sc = cnt;
         if (cnt >= MINS && cnt <= MAXS) rv++;
      end
   endfunction

   function automatic void model_hyst(input bit hit);
      if (m_det == 0) begin
         if (hit) begin
            m_hit++;
            m_miss = 0;
            if (m_hit >= CONF) begin m_det = 1; m_hit = 0; end
         end else m_hit = 0;
      end else begin
         if (!hit) begin
            m_miss++;
            m_hit = 0;
            if (m_miss >= REL) begin m_det = 0; m_miss = 0; end
         end else m_miss = 0;
      end
   endfunction

   // ---------------- drivers ----------------
   // Called at #1 after a rising edge; returns #1 after the accepting edge.
   task automatic push(input logic [7:0] d);
      int guard;
      x_valid = 1'b1;
      x_data  = d;
      guard   = 0;
      while (!x_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!x_ready) check("ready_timeout", 0, 1);
      @(posedge clk); #1;
      x_valid = 1'b0;
   endtask

   task automatic idle_gap(input int gaps);
      int k;
      if (gaps != 0) begin
         k = $urandom_range(0, 3);
         x_valid = 1'b0;
         repeat (k) begin @(posedge clk); #1; end
      end
   endtask

   task automatic run_frame(input string name, input int gaps, input int scramble);
      int sc, rv, thr0;
      thr0 = int'(threshold);
      model_frame(thr0, sc, rv);
      model_hyst(rv >= VOTES);
      for (int p = 0; p < IMG_W * IMG_H; p++) begin
         idle_gap(gaps);
         push(frm[p / IMG_W][p % IMG_W]);
         if (scramble != 0 && (p % 97) == 0) threshold = 8'($urandom_range(0, 255));
      end
      threshold = 8'(thr0);
      // T+1: evaluate cycle
      check({name, ".eval_ready"}, int'(x_ready), 0);
      check({name, ".eval_dv"}, int'(detection_valid), 0);
      @(posedge clk); #1;
      // T+2: report cycle
      check({name, ".dv"}, int'(detection_valid), 1);
      check({name, ".rep_ready"}, int'(x_ready), 0);
      check({name, ".stripes"}, int'(stripe_count), sc);
      check({name, ".rows"}, int'(rows_voted), rv);
      check({name, ".cross"}, int'(crossing_detected), m_det);
      @(posedge clk); #1;
      // T+3: scanning again
      check({name, ".dv_end"}, int'(detection_valid), 0);
      check({name, ".ready_back"}, int'(x_ready), 1);
   endtask

   task automatic run_partial(input int npix);
      for (int p = 0; p < npix; p++) begin
         idle_gap(1);
         push(frm[p / IMG_W][p % IMG_W]);
         if ((p % 53) == 0) threshold = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".cross"}, int'(crossing_detected), 0);
      check({name, ".dv"}, int'(detection_valid), 0);
      check({name, ".stripes"}, int'(stripe_count), 0);
      check({name, ".rows"}, int'(rows_voted), 0);
      check({name, ".ready"}, int'(x_ready), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst       = 1'b1;
      x_valid   = 1'b0;
      x_data    = '0;
      threshold = 8'd128;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      rst = 1'b0;
      @(posedge clk); #1;
      check("por.ready_after", int'(x_ready), 1);

      for (int y = 0; y < IMG_H; y++)
         for (int x = 0; x < IMG_W; x++) frm[y][x] = 8'd0;
      run_frame("zero", 0, 0);

      fill_bars(6, 4, 4'b1111);  run_frame("bars6_a", 0, 0);
      fill_bars(3, 4, 4'b1111);  run_frame("bars3", 0, 0);
      fill_bars(6, 4, 4'b1111);  run_frame("bars6_b", 0, 0);
      fill_bars(6, 4, 4'b1111);  run_frame("bars6_c", 0, 0);
      fill_boundary();           run_frame("edge", 0, 0);

      fill_bars(6, 4, 4'b0000);  run_frame("blk1", 0, 0);
      fill_bars(6, 4, 4'b0000);  run_frame("blk2", 0, 0);
      fill_bars(6, 4, 4'b1111);  run_frame("refresh", 0, 0);
      fill_bars(6, 4, 4'b0000);  run_frame("blk3", 0, 0);
      fill_bars(6, 4, 4'b0000);  run_frame("blk4", 0, 0);
      fill_bars(6, 4, 4'b0000);  run_frame("blk5", 0, 0);

      fill_bars(6, 4, 4'b0101);  run_frame("two_rows", 0, 0);
      fill_bars(4, 7, 4'b1111);  run_frame("seven", 0, 0);

      fill_bars(5, 5, 4'b1111);  run_frame("pre_rst_a", 1, 0);
      fill_bars(5, 5, 4'b1111);  run_frame("pre_rst_b", 0, 0);

      // asynchronous reset in the middle of row 5
      fill_random();
      run_partial(5 * IMG_W + 10);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_rst");
      threshold = 8'd128;
      @(posedge clk); #1;
      rst = 1'b0;
      m_det  = 0;
      m_hit  = 0;
      m_miss = 0;

      fill_bars(6, 4, 4'b1111);  run_frame("post_rst_a", 1, 1);
      fill_bars(6, 4, 4'b1111);  run_frame("post_rst_b", 1, 1);

      for (int f = 0; f < 6; f++) begin
         fill_random();
         run_frame($sformatf("rand%0d", f), f % 2, f % 3 == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
